// File: rtl/alu_cmd_issuer_pkg.sv
// Purpose: shared ALU op encodings, issuer FSM state codes and command FIFO entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_cmd_issuer_pkg;

    // ALU control encodings (2-bit control pins of the registered ALU)
    localparam logic [1:0] ALU_CLR  = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_HOLD = 2'b11;

    // Issuer FSM state encoding, kept as plain constants so the codes stay fixed
    typedef logic [2:0] issue_state_t;
    localparam issue_state_t ST_INIT    = 3'd0;
    localparam issue_state_t ST_IDLE    = 3'd1;
    localparam issue_state_t ST_ISSUE   = 3'd2;
    localparam issue_state_t ST_CAPTURE = 3'd3;
    localparam issue_state_t ST_RESP    = 3'd4;

    // One queued command: {op, x, y, tag}, 12 bits
    typedef struct packed {
        logic [1:0] op;
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] tag;
    } cmd_entry_t;

    localparam int CMD_W = $bits(cmd_entry_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// Purpose: generic synchronous FIFO with occupancy count, head entry visible on rd_dat.
// Latency: a pushed entry is visible on rd_dat the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on count.
// Ports: clk, rst_n (async active-low); push/wr_dat write side; pop/rd_dat read side;
//        count = current occupancy (0..DEPTH).
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && (count != '0);
    assign rd_dat  = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Purpose: queues ALU commands, drives the registered ALU one command at a time, returns tagged results.
// Latency: push into empty FIFO at E0 -> pop E1 -> ALU samples E2 -> rsp_valid high after E3; 3 cycles/result back-to-back.
// Backpressure: cmd_ready drops when the FIFO is full; rsp_ready low parks the FSM in RESP with rsp_* held.
// Ports: cmd_* command in (valid/ready), alu_x/alu_y/alu_ctrl to ALU, alu_result from ALU,
//        rsp_* tagged result out (valid/ready), busy and fifo_count status.
module alu_cmd_issuer
    import alu_cmd_issuer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [3:0]              cmd_x,
    input  logic [3:0]              cmd_y,
    input  logic [1:0]              cmd_tag,
    output logic [3:0]              alu_x,
    output logic [3:0]              alu_y,
    output logic [1:0]              alu_ctrl,
    input  logic [3:0]              alu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [3:0]              rsp_data,
    output logic [1:0]              rsp_tag,
    output logic                    rsp_zero,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    issue_state_t state;
    cmd_entry_t   wr_entry;
    cmd_entry_t   head;
    logic [1:0]   tag_q;
    logic         push;
    logic         pop;
    logic         fifo_nonempty;

    // Ready comes from the registered count only, so a full FIFO stays
    // closed even in a cycle where it is also being popped.
    assign cmd_ready     = (fifo_count != FULL_CNT);
    assign push          = cmd_valid && cmd_ready;
    assign fifo_nonempty = (fifo_count != '0);
    // In RESP rsp_valid is always high, so rsp_ready alone marks the handshake.
    assign pop           = fifo_nonempty &&
                           ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
    assign busy          = (state != ST_IDLE) || fifo_nonempty;

    assign wr_entry = {cmd_op, cmd_x, cmd_y, cmd_tag};

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .wr_dat (wr_entry),
        .pop    (pop),
        .rd_dat (head),
        .count  (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            alu_x     <= '0;
            alu_y     <= '0;
            alu_ctrl  <= ALU_CLR;   // clears the ALU result register during/after reset
            tag_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
            rsp_zero  <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    alu_ctrl <= ALU_HOLD;
                    state    <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (pop) begin
                        alu_x    <= head.x;
                        alu_y    <= head.y;
                        alu_ctrl <= head.op;
                        tag_q    <= head.tag;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // ALU samples the operation on this edge; hold from here on.
                    alu_ctrl <= ALU_HOLD;
                    state    <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rsp_data  <= alu_result;
                    rsp_tag   <= tag_q;
                    rsp_zero  <= (alu_result == 4'd0);
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (pop) begin
                            alu_x    <= head.x;
                            alu_y    <= head.y;
                            alu_ctrl <= head.op;
                            tag_q    <= head.tag;
                            state    <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    alu_ctrl <= ALU_CLR;
                    state    <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Purpose: directed bench for alu_cmd_issuer with a behavioural registered ALU attached.
// Latency: checks the push->response timing and 3-cycle issue rhythm.
// Backpressure: exercises rsp_ready stall with a full command FIFO.
module tb_alu_cmd_issuer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_x = 4'd0;
    logic [3:0] cmd_y = 4'd0;
    logic [1:0] cmd_tag = 2'd0;
    logic [3:0] alu_x;
    logic [3:0] alu_y;
    logic [1:0] alu_ctrl;
    logic [3:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic [1:0] rsp_tag;
    logic       rsp_zero;
    logic       busy;
    logic [2:0] fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Behavioural 4-bit registered ALU; powers up non-zero so the clear is visible.
    logic [3:0] alu_q = 4'd9;
    always @(posedge clk) begin
        case (alu_ctrl)
            2'b00:   alu_q <= 4'd0;
            2'b01:   alu_q <= alu_x + alu_y;
            2'b10:   alu_q <= alu_x - alu_y;
            default: alu_q <= alu_q;
        endcase
    end
    assign alu_result = alu_q;

    alu_cmd_issuer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_tag    (cmd_tag),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_zero   (rsp_zero),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    // Present a command from a negedge; returns at the negedge after the accepting edge
    // with cmd_valid still high so calls can be chained back-to-back.
    task automatic send(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                        input logic [1:0] tag);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        cmd_tag   = tag;
        for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: cmd_ready=%b required 1 (tag %0d)", cmd_ready, tag);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait (bounded) for a response, sample it, then complete the handshake.
    task automatic wait_rsp(output logic got, output logic [3:0] d, output logic [1:0] t,
                            output logic z);
        rsp_ready = 1'b1;
        for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge clk);
        got = rsp_valid;
        d   = rsp_data;
        t   = rsp_tag;
        z   = rsp_zero;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (alu_ctrl !== 2'b00 || alu_x !== 4'd0 || alu_y !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_alu_drive: ctrl=%b x=%0d y=%0d required 00/0/0", alu_ctrl, alu_x, alu_y);
        end
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_data !== 4'd0 || rsp_tag !== 2'd0 || rsp_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp: v=%b d=%0d t=%0d z=%b required all 0", rsp_valid, rsp_data, rsp_tag, rsp_zero);
        end
        n_tests++;
        if (fifo_count !== 3'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_status: count=%0d busy=%b required 0/1", fifo_count, busy);
        end
        rst_n = 1'b1;
        n_tests++;
        if (cmd_ready !== 1'b1 || alu_ctrl !== 2'b00) begin
            n_fail++;
            $display("FAIL release_cycle: ready=%b ctrl=%b required 1/00", cmd_ready, alu_ctrl);
        end
        @(negedge clk);
        n_tests++;
        if (alu_ctrl !== 2'b11 || busy !== 1'b0 || alu_q !== 4'd0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_init: ctrl=%b busy=%b alu=%0d v=%b required 11/0/0/0", alu_ctrl, busy, alu_q, rsp_valid);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (alu_ctrl !== 2'b11 || rsp_valid !== 1'b0 || alu_q !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_hold: ctrl=%b v=%b alu=%0d required 11/0/0", alu_ctrl, rsp_valid, alu_q);
        end
    endtask

    task automatic test_single_add;
        rsp_ready = 1'b0;
        send(2'b01, 4'd7, 4'd5, 2'd2);
        cmd_valid = 1'b0;
        n_tests++;
        if (fifo_count !== 3'd1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_n0: count=%0d v=%b required 1/0", fifo_count, rsp_valid);
        end
        @(negedge clk);
        n_tests++;
        if (alu_ctrl !== 2'b01 || alu_x !== 4'd7 || alu_y !== 4'd5 || fifo_count !== 3'd0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_issue: ctrl=%b x=%0d y=%0d count=%0d v=%b required 01/7/5/0/0",
                     alu_ctrl, alu_x, alu_y, fifo_count, rsp_valid);
        end
        @(negedge clk);
        n_tests++;
        if (alu_ctrl !== 2'b11 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_capture: ctrl=%b v=%b required 11/0", alu_ctrl, rsp_valid);
        end
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 4'd12 || rsp_tag !== 2'd2 || rsp_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL add_rsp: v=%b d=%0d t=%0d z=%b required 1/12/2/0", rsp_valid, rsp_data, rsp_tag, rsp_zero);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL add_done: v=%b busy=%b required 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_wrap_sub;
        logic [1:0] ops  [3] = '{2'b01, 2'b10, 2'b10};
        logic [3:0] xs   [3] = '{4'd9, 4'd3, 4'd4};
        logic [3:0] ys   [3] = '{4'd9, 4'd5, 4'd4};
        logic [1:0] tags [3] = '{2'd0, 2'd1, 2'd3};
        logic [3:0] exps [3] = '{4'd2, 4'd14, 4'd0};
        logic got, z;
        logic [3:0] d;
        logic [1:0] t;
        for (int i = 0; i < 3; i++) begin
            send(ops[i], xs[i], ys[i], tags[i]);
            cmd_valid = 1'b0;
            wait_rsp(got, d, t, z);
            n_tests++;
            if (!got || d !== exps[i] || t !== tags[i] || z !== (exps[i] == 4'd0)) begin
                n_fail++;
                $display("FAIL wrap_sub[%0d]: got=%b d=%0d t=%0d z=%b required 1/%0d/%0d/%b",
                         i, got, d, t, z, exps[i], tags[i], (exps[i] == 4'd0));
            end
        end
    endtask

    task automatic test_back_to_back_full;
        logic [1:0] ops  [6] = '{2'b01, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01};
        logic [3:0] xs   [6] = '{4'd1, 4'd2, 4'd15, 4'd5, 4'd6, 4'd8};
        logic [3:0] ys   [6] = '{4'd2, 4'd5, 4'd15, 4'd5, 4'd6, 4'd8};
        logic [1:0] tags [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0] exps [6] = '{4'd3, 4'd13, 4'd14, 4'd14, 4'd0, 4'd0};
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(ops[i], xs[i], ys[i], tags[i]);
        cmd_valid = 1'b1;
        cmd_op    = ops[5];
        cmd_x     = xs[5];
        cmd_y     = ys[5];
        cmd_tag   = tags[5];
        repeat (2) @(negedge clk);
        n_tests++;
        if (fifo_count !== 3'd4 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL full: count=%0d ready=%b busy=%b required 4/0/1", fifo_count, cmd_ready, busy);
        end
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 4'd3 || rsp_tag !== 2'd0 || rsp_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_rsp: v=%b d=%0d t=%0d z=%b required 1/3/0/0", rsp_valid, rsp_data, rsp_tag, rsp_zero);
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 4'd3 || rsp_tag !== 2'd0 || fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_stable: v=%b d=%0d t=%0d count=%0d ready=%b required 1/3/0/4/0",
                     rsp_valid, rsp_data, rsp_tag, fifo_count, cmd_ready);
        end
        rsp_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
                @(posedge clk);
                @(negedge clk);
                cmd_valid = 1'b0;
            end
            begin
                logic got, z;
                logic [3:0] d;
                logic [1:0] t;
                for (int i = 0; i < 6; i++) begin
                    wait_rsp(got, d, t, z);
                    n_tests++;
                    if (!got || d !== exps[i] || t !== tags[i] || z !== (exps[i] == 4'd0)) begin
                        n_fail++;
                        $display("FAIL b2b[%0d]: got=%b d=%0d t=%0d z=%b required 1/%0d/%0d/%b",
                                 i, got, d, t, z, exps[i], tags[i], (exps[i] == 4'd0));
                    end
                end
            end
        join
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || fifo_count !== 3'd0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: busy=%b count=%0d v=%b required 0/0/0", busy, fifo_count, rsp_valid);
        end
    endtask

    task automatic test_hold_clear;
        logic got, z;
        logic [3:0] d;
        logic [1:0] t;
        send(2'b01, 4'd3, 4'd4, 2'd1);
        cmd_valid = 1'b0;
        wait_rsp(got, d, t, z);
        n_tests++;
        if (!got || d !== 4'd7 || t !== 2'd1 || z !== 1'b0) begin
            n_fail++;
            $display("FAIL hc_add: got=%b d=%0d t=%0d z=%b required 1/7/1/0", got, d, t, z);
        end
        send(2'b11, 4'd2, 4'd9, 2'd2);
        cmd_valid = 1'b0;
        wait_rsp(got, d, t, z);
        n_tests++;
        if (!got || d !== 4'd7 || t !== 2'd2 || z !== 1'b0) begin
            n_fail++;
            $display("FAIL hc_hold: got=%b d=%0d t=%0d z=%b required 1/7/2/0", got, d, t, z);
        end
        send(2'b00, 4'd15, 4'd15, 2'd3);
        cmd_valid = 1'b0;
        wait_rsp(got, d, t, z);
        n_tests++;
        if (!got || d !== 4'd0 || t !== 2'd3 || z !== 1'b1) begin
            n_fail++;
            $display("FAIL hc_clear: got=%b d=%0d t=%0d z=%b required 1/0/3/1", got, d, t, z);
        end
    endtask

    task automatic test_reset_midflight;
        logic got, z;
        logic [3:0] d;
        logic [1:0] t;
        int stale;
        rsp_ready = 1'b1;
        send(2'b01, 4'd1, 4'd1, 2'd0);
        send(2'b01, 4'd2, 4'd2, 2'd1);
        send(2'b01, 4'd3, 4'd3, 2'd2);
        cmd_valid = 1'b0;
        n_tests++;
        if (fifo_count !== 3'd2 || rsp_valid !== 1'b0 || alu_ctrl !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_pre: count=%0d v=%b ctrl=%b required 2/0/11", fifo_count, rsp_valid, alu_ctrl);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0 || fifo_count !== 3'd0 || alu_ctrl !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset: v=%b count=%0d ctrl=%b required 0/0/00", rsp_valid, fifo_count, alu_ctrl);
        end
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) stale++;
        end
        n_tests++;
        if (stale != 0 || busy !== 1'b0 || alu_q !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_stale: stale_cycles=%0d busy=%b alu=%0d required 0/0/0", stale, busy, alu_q);
        end
        send(2'b01, 4'd2, 4'd3, 2'd1);
        cmd_valid = 1'b0;
        wait_rsp(got, d, t, z);
        n_tests++;
        if (!got || d !== 4'd5 || t !== 2'd1 || z !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: got=%b d=%0d t=%0d z=%b required 1/5/1/0", got, d, t, z);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_add();
        test_wrap_sub();
        test_back_to_back_full();
        test_hold_clear();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-side front end for the 4-bit registered ALU (clear/add/subtract/hold, 2-bit control, result registered on the clock edge).
- Accepts ALU commands over a valid/ready interface into a small FIFO, drives the ALU operand and control inputs one command at a time, and captures the registered result.
- Returns each result with its tag and a zero flag over a valid/ready response interface.
- Sits directly upstream of the ALU and owns its control pins: it also clears the ALU result register once after reset and holds it between commands.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept (count < DEPTH).
- cmd_op  in  2  00 clear, 01 add, 10 sub, 11 hold.
- cmd_x, cmd_y  in  4 each  operands.
- cmd_tag  in  2  opaque ID returned with result.
- alu_x, alu_y  out  4 each  to ALU operand inputs (registered).
- alu_ctrl  out  2  to ALU control input (registered).
- alu_result  in  4  ALU registered output.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  4  captured ALU result.
- rsp_tag  out  2  tag of the command.
- rsp_zero  out  1  rsp_data == 0.
- busy  out  1  state ≠ IDLE or FIFO non-empty.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO: push on cmd_valid && cmd_ready. Entry = {op, x, y, tag}, 12 bits. Pop only in IDLE, or in RESP on handshake, when non-empty.
- Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.
- cmd_ready = fifo_count < DEPTH, from registered count only. A full FIFO deasserts ready even if a pop occurs that cycle.
- FSM states:
  - INIT: reset state; alu_ctrl = 00, clearing the ALU. Next edge: alu_ctrl ← 11, go IDLE.
  - IDLE: if FIFO non-empty, pop and load alu_x/alu_y/alu_ctrl from the head entry, latch the tag, go ISSUE. Otherwise stay.
  - ISSUE: ALU samples on this cycle's closing edge. At that edge alu_ctrl ← 11 (hold), go CAPTURE.
  - CAPTURE: alu_result is valid. rsp_data ← alu_result, rsp_tag ← latched tag, rsp_zero ← (alu_result == 0), rsp_valid ← 1, go RESP.
  - RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On handshake, rsp_valid ← 0. Then, if FIFO non-empty, pop and load the ALU regs, go ISSUE; else go IDLE.
- Op 11 (hold): issued unchanged; returns the current ALU register value.
- Arithmetic is the ALU's mod-16 add/sub. No carry or borrow is reported.
- alu_ctrl is 11 in every state except INIT and ISSUE.
- cmd_ready is independent of FSM state. Commands are accepted during INIT, ISSUE, CAPTURE and RESP.

## Timing
- Reset (async assert, sync-to-clock release): state INIT, FIFO empty, fifo_count 0, alu_ctrl 00, alu_x/alu_y 0, rsp_valid 0, rsp_data 0, rsp_tag 0, rsp_zero 0. busy = 1 while in INIT.
- cmd_ready is 1 from the first cycle after reset release.
- Latency: push at edge E0 into an empty FIFO in IDLE → pop at E1 → ALU samples at E2 → rsp_valid high after E3.
- Back-to-back throughput with rsp_ready tied high: one response per 3 cycles (ISSUE, CAPTURE, RESP).
- rsp_ready low stalls the FSM in RESP. The FIFO continues to fill until full.
- Reset mid-operation: in-flight command and FIFO contents are discarded with no response. The ALU is re-cleared via INIT.

## Structure
- Shared package: op encodings (ALU_CLR=00, ALU_ADD=01, ALU_SUB=10, ALU_HOLD=11), FSM state enum, FIFO entry struct {op, x, y, tag}.
- One sub-module: alu_cmd_fifo. Parameterised DEPTH and WIDTH, synchronous push/pop, count output, async active-low reset.
- FSM, ALU-drive registers and response registers live in the top.

## Test plan
- Reset then idle: after rst_n release, alu_ctrl = 00 for exactly one cycle, then 11. Model ALU output reads 0. rsp_valid stays 0, busy drops after INIT.
- Single add: push {01, x=7, y=5, tag=2} → rsp_valid 3 cycles after push, rsp_data=12, rsp_tag=2, rsp_zero=0.
- Wrap/subtract: push {01, 9, 9, 0}, then {10, 3, 5, 1} → rsp_data 2 then 14. Then {10, 4, 4, 3} → rsp_data 0, rsp_zero=1.
- Backpressure and full:
  - Hold rsp_ready=0 and push 6 commands back-to-back with DEPTH=4.
  - One command is in flight, 4 are buffered, cmd_ready=0 and the 6th is held.
  - Release rsp_ready: all 6 return in order with correct tags, rsp_* stable while stalled.
- Hold and clear ops: add 3+4, then push {11, x, y, tag} → rsp_data 7. Push {00, 15, 15, tag} → rsp_data 0, rsp_zero=1.
- Reset mid-flight: assert rst_n low while in CAPTURE with 2 queued → rsp_valid 0 immediately, fifo_count 0. No stale responses after release, and the next command returns correctly.
